and_gate_checker: RTL

AND_GATE_CHECKER -- requirements
Module: and_gate_checker

---
 rtl/and_gate_checker_if.sv | 47 ++++
 rtl/and_gate_checker.sv | 109 ++++++++++
 2 files changed

// File: rtl/and_gate_checker_if.sv
// Signal bundle between the AND-gate sweep checker and its environment.
// master = checker side, slave = device/stimulus side.
interface and_gate_checker_if #(
  parameter int unsigned N_BITS = 4
);

  logic                start;
  logic [N_BITS-1:0]   A;
  logic [N_BITS-1:0]   B;
  logic [N_BITS-1:0]   C;
  logic                busy;
  logic                done;
  logic                pass;
  logic [2*N_BITS:0]   err_count;
  logic                fail_valid;
  logic [N_BITS-1:0]   fail_a;
  logic [N_BITS-1:0]   fail_b;

  modport master (
    input  start,
    input  C,
    output A,
    output B,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_valid,
    output fail_a,
    output fail_b
  );

  modport slave (
    output start,
    output C,
    input  A,
    input  B,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_valid,
    input  fail_a,
    input  fail_b
  );

endinterface

// File: rtl/and_gate_checker.sv
// Exhaustive sweep checker for an N_BITS-wide bitwise-AND device: drives every {B,A}
// pair once, counts mismatches and captures the first failing vector.
module and_gate_checker #(
  parameter int unsigned N_BITS = 4
) (
  input logic                 clk,
  input logic                 reset,
  and_gate_checker_if.master  bus
);

  localparam int unsigned CntW = 2 * N_BITS;
  localparam int unsigned ErrW = 2 * N_BITS + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ErrW-1:0]     err_q, err_d;
  logic                pass_q, pass_d;
  logic                fail_valid_q, fail_valid_d;
  logic [N_BITS-1:0]   fail_a_q, fail_a_d;
  logic [N_BITS-1:0]   fail_b_q, fail_b_d;

  logic [N_BITS-1:0]   vec_a, vec_b;
  logic                mismatch;

  // A/B are taken straight from the counter register, so they advance with cnt.
  assign vec_a    = cnt_q[N_BITS-1:0];
  assign vec_b    = cnt_q[CntW-1:N_BITS];
  assign mismatch = (bus.C != (vec_a & vec_b));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    pass_d       = pass_q;
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d      = StRun;
          cnt_d        = '0;
          err_d        = '0;
          pass_d       = 1'b0;
          fail_valid_d = 1'b0;
          fail_a_d     = '0;
          fail_b_d     = '0;
        end
      end
      StRun: begin
        if (mismatch) begin
          err_d = err_q + ErrW'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_a_d     = vec_a;
            fail_b_d     = vec_b;
          end
        end
        if (cnt_q == {CntW{1'b1}}) begin
          // Final compare is folded into err_d, so pass reflects the whole sweep.
          state_d = StDone;
          pass_d  = (err_d == '0);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
    end
  end

  assign bus.A          = vec_a;
  assign bus.B          = vec_b;
  assign bus.busy       = (state_q == StRun);
  assign bus.done       = (state_q == StDone);
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_a     = fail_a_q;
  assign bus.fail_b     = fail_b_q;

endmodule
